demux_1_n_hs_v: RTL
===================

Name: demux_1_n_hs_v

Overview:
Parametrised, registered 1-to-N demultiplexer. It is the clocked successor of the combinational 1-to-4 demux/decoder with one active-high and two active-low chip selects. A single valid/ready input stream is steered to one of N_CH output channels. Each channel has its own output register and valid/ready handshake. An addressed mode (channel chosen by i_sel) and a round-robin mode (internal pointer) are provided. The block sits between a single producer and N_CH independent consumers in the datapath.

Parameters:
WIDTH, 4, data bits per beat (>=1)
N_CH, 4, number of output channels (2..16; need not be a power of 2)
SEL_W, 2, select/pointer width; must satisfy 2**SEL_W >= N_CH

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_cs  input  1  chip select, active-high
i_n_cs_0  input  1  chip select, active-low
i_n_cs_1  input  1  chip select, active-low
i_mode  input  1  0 = addressed (i_sel), 1 = round-robin (internal pointer)
i_sel  input  SEL_W  target channel in addressed mode
i_data  input  WIDTH  input beat
i_valid  input  1  input beat valid
o_ready  output  1  block accepts the beat this cycle
o_data  output  N_CH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
o_valid  output  N_CH  per-channel valid
i_ready  input  N_CH  per-channel consumer ready
o_rr_ptr  output  SEL_W  current round-robin pointer
o_err  output  1  one-cycle pulse: addressed beat to a non-existent channel

Behaviour:
- Clocking: single clock i_clk. Reset is synchronous and active-low (i_rst_n sampled on the rising edge).
- Reset values: o_valid = 0 all channels, o_data = 0, o_rr_ptr = 0, o_err = 0. Reset mid-operation discards all held beats. The reset cycle accepts nothing.
- en = i_cs & ~i_n_cs_0 & ~i_n_cs_1 (combinational).
- Target channel t = i_mode ? o_rr_ptr : i_sel. i_sel is ignored in round-robin mode.
- in_range = (t < N_CH). In round-robin mode in_range is always true.
- o_ready = en & in_range & (~o_valid[t] | i_ready[t]). This path is combinational from i_sel, i_mode, chip selects and i_ready[t].
- Accept = i_valid & o_ready. On accept, in the next cycle: o_data[t] = i_data and o_valid[t] = 1. Latency is 1 clock from accepted beat to o_valid.
- Per channel k, priority per edge:
  - load if (accept & t==k);
  - else clear o_valid[k] if (o_valid[k] & i_ready[k]);
  - else hold.
  - Simultaneous drain and load on the same channel gives back-to-back beats with no bubble, which is full throughput.
- Non-target channels keep their data and drain independently. o_data[k] holds its last value after valid drops; it is not cleared.
- Round-robin pointer:
  - advances only on accept in mode 1;
  - wraps N_CH-1 -> 0;
  - holds in mode 0;
  - mode switches do not reset it.
- Disabled (en=0): o_ready = 0 and no loads, but channels still drain via i_ready. The pointer holds.
- o_err = 1 for exactly one cycle (registered) after any cycle with en & i_valid & ~i_mode & (i_sel >= N_CH). The beat is not accepted and no channel changes.
- i_valid low: no state change other than draining.
- The block has no internal FIFO. Depth is one beat per channel.

Test Plan:
- Reset/enable: assert i_rst_n=0 for 2 clocks with i_valid=1, then apply en combos (cs,n0,n1) = 100, 000, 110, 101 -> all o_valid=0, o_data=0, o_rr_ptr=0 after reset; o_ready=1 only for 100.
- Addressed steering: WIDTH=4, N_CH=4, i_ready=4'b1111, send data 0xA..0xD with sel 0..3 on consecutive cycles -> each o_valid[k] pulses 1 cycle after its beat with o_data[k]=0xA+k; o_ready stays 1.
- Backpressure: i_ready[2]=0, send 0x5 then 0x6 to ch 2 -> first beat loaded, then o_ready=0 and 0x6 held at the input; raise i_ready[2] -> 0x5 drains, 0x6 loads the same edge, no bubble.
- Round-robin: i_mode=1, N_CH=3, 7 beats 1..7, all ready -> ch0 gets 1,4,7; ch1 gets 2,5; ch2 gets 3,6; o_rr_ptr sequence 0,1,2,0,1,2,0,1; stall one cycle (i_valid=0) -> pointer holds.
- Out of range: N_CH=3, SEL_W=2, i_sel=3, i_valid=1 -> o_ready=0, o_err=1 for one cycle, no o_valid change; i_mode=1 with i_sel=3 -> accepted, no o_err.
- Reset mid-operation: two channels hold valid beats and i_ready=0, assert i_rst_n=0 for one clock -> all o_valid=0, o_data=0, o_rr_ptr=0 on the next cycle.

Source files
------------

// File: rtl/demux_1_n_hs_v.sv
// demux_1_n_hs_v: registered 1-to-N valid/ready demultiplexer with addressed and round-robin steering
module demux_1_n_hs_v #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cs,
    input  logic                  i_n_cs_0,
    input  logic                  i_n_cs_1,
    input  logic                  i_mode,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [N_CH*WIDTH-1:0] o_data,
    output logic [N_CH-1:0]       o_valid,
    input  logic [N_CH-1:0]       i_ready,
    output logic [SEL_W-1:0]      o_rr_ptr,
    output logic                  o_err
);
    localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

    logic             en;
    logic             in_range;
    logic             acc;
    logic [SEL_W-1:0] t;
    logic [N_CH-1:0]  hit;

    assign en       = i_cs & ~i_n_cs_0 & ~i_n_cs_1;
    assign t        = i_mode ? o_rr_ptr : i_sel;
    assign in_range = i_mode | ({1'b0, t} < NCH);
    assign o_ready  = en & in_range & |hit;
    assign acc      = i_valid & o_ready;

    // per-channel "target slot can take a beat": empty, or draining this edge
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_CH; k++)
            hit[k] = (t == SEL_W'(k)) & (~o_valid[k] | i_ready[k]);
    end

    // channel registers: load beats priority over drain, so load+drain is bubble-free
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= '0;
            o_data  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (acc && t == SEL_W'(k)) begin
                    o_data[k*WIDTH +: WIDTH] <= i_data;
                    o_valid[k]               <= 1'b1;
                end else if (o_valid[k] && i_ready[k]) begin
                    o_valid[k] <= 1'b0;
                end
            end
        end
    end

    // round-robin pointer advances per accepted beat; error flags addressed beats past the last channel
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rr_ptr <= '0;
            o_err    <= 1'b0;
        end else begin
            if (acc && i_mode)
                o_rr_ptr <= (o_rr_ptr == LAST) ? '0 : o_rr_ptr + 1'b1;
            o_err <= en & i_valid & ~i_mode & ~in_range;
        end
    end
endmodule
